// File: rtl/dispatch_queue_pkg.sv
// Shared encodings for the dispatch queue: op classes, dispatch targets, tag constants.
package dispatch_queue_pkg;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned CLS_W = 4;

  // Tag value meaning "operand ready / no destination tag".
  localparam int unsigned TAG_FREE = 0;

  // Tag MSB selects the free-tag pool that issued it.
  localparam logic PREFIX_ALU = 1'b0;
  localparam logic PREFIX_LS  = 1'b1;

  typedef enum logic [CLS_W-1:0] {
    ClsNone  = 4'd0,
    ClsLui   = 4'd1,
    ClsAuipc = 4'd2,
    ClsJal   = 4'd3,
    ClsJalr  = 4'd4,
    ClsB     = 4'd5,
    ClsLd    = 4'd6,
    ClsSt    = 4'd7,
    ClsRi    = 4'd8,
    ClsRr    = 4'd9
  } dq_cls_e;

  typedef enum logic [1:0] {
    TgtNone = 2'd0,
    TgtAlu  = 2'd1,
    TgtBr   = 2'd2,
    TgtLs   = 2'd3
  } dq_tgt_e;

  // Execution unit that consumes a given class.
  function automatic dq_tgt_e cls_target(dq_cls_e cls);
    case (cls)
      ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsRi, ClsRr: return TgtAlu;
      ClsB:                                            return TgtBr;
      ClsLd, ClsSt:                                    return TgtLs;
      default:                                         return TgtNone;
    endcase
  endfunction

  // Classes whose destination is renamed from the ALU free-tag pool.
  function automatic logic cls_alu_rename(dq_cls_e cls);
    case (cls)
      ClsLui, ClsAuipc, ClsJal, ClsJalr, ClsRi, ClsRr: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dq_fifo.sv
// Circular storage for queued instructions; count register disambiguates full/empty.
module dq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CntW'(DEPTH));
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer and occupancy next-state; flush empties the queue without touching contents.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/dispatch_queue.sv
// In-order dispatch queue: buffers decoded ops, reads sources at the head, renames the
// destination from the free-tag pools and hands the op to the ALU, branch or load/store unit.
module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROOT_W = 4,
  parameter int unsigned NAME_W = 5,
  localparam int unsigned TAG_W = ROOT_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CLS_W-1:0]  in_cls,
  input  logic [OP_W-1:0]   in_op,
  input  logic [NAME_W-1:0] in_rs1,
  input  logic [NAME_W-1:0] in_rs2,
  input  logic [NAME_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_imm,
  output logic [NAME_W-1:0] rf_name1,
  output logic [NAME_W-1:0] rf_name2,
  input  logic [TAG_W-1:0]  rf_tag1,
  input  logic [TAG_W-1:0]  rf_tag2,
  input  logic [DATA_W-1:0] rf_data1,
  input  logic [DATA_W-1:0] rf_data2,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              alu_free_valid,
  input  logic [ROOT_W-1:0] alu_free_tag,
  input  logic              ls_free_valid,
  input  logic [ROOT_W-1:0] ls_free_tag,
  output logic              ren_en,
  output logic [NAME_W-1:0] ren_name,
  output logic [TAG_W-1:0]  ren_tag,
  output logic              alu_valid,
  output logic              br_valid,
  output logic              ls_valid,
  input  logic              alu_ready,
  input  logic              br_ready,
  input  logic              ls_ready,
  output logic [OP_W-1:0]   d_op,
  output logic [DATA_W-1:0] d_opnd1,
  output logic [DATA_W-1:0] d_opnd2,
  output logic [TAG_W-1:0]  d_tag1,
  output logic [TAG_W-1:0]  d_tag2,
  output logic [TAG_W-1:0]  d_tagw,
  output logic [NAME_W-1:0] d_namew,
  output logic [DATA_W-1:0] d_imm,
  output logic [DATA_W-1:0] d_addr,
  output logic [31:0]       stall_cnt
);

  localparam logic [TAG_W-1:0] TagFree = TAG_W'(TAG_FREE);

  typedef struct packed {
    logic [CLS_W-1:0]  cls;
    logic [OP_W-1:0]   op;
    logic [NAME_W-1:0] rs1;
    logic [NAME_W-1:0] rs2;
    logic [NAME_W-1:0] rd;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] imm;
  } entry_t;

  localparam int unsigned EntryW = $bits(entry_t);

  entry_t  in_entry, head;
  logic    push, fire, head_valid, empty, full;
  dq_cls_e cls;
  dq_tgt_e tgt;
  logic    rd_nz, needs_alu_tag, needs_ls_tag, tag_ok, tgt_ready, go, renames;
  logic    [TAG_W+DATA_W-1:0] src1, src2;
  logic    [31:0] stall_q, stall_d;

  assign in_entry = '{cls: in_cls, op: in_op, rs1: in_rs1, rs2: in_rs2, rd: in_rd,
                      addr: in_addr, imm: in_imm};

  assign in_ready = !full;
  // No bypass: an op entering this cycle is first visible at the head next cycle.
  assign push     = in_valid && in_ready && !flush;

  dq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .wdata_i (in_entry),
    .pop_i   (fire),
    .rdata_o (head),
    .empty_o (empty),
    .full_o  (full)
  );

  assign head_valid = !empty;
  assign cls        = dq_cls_e'(head.cls);
  assign tgt        = cls_target(cls);
  assign rd_nz      = (head.rd != '0);
  assign rf_name1   = head.rs1;
  assign rf_name2   = head.rs2;

  // Source value: x0 is hardwired zero; a matching broadcast supersedes a pending tag.
  function automatic logic [TAG_W+DATA_W-1:0] resolve_src(
    input logic [NAME_W-1:0] name,
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] data,
    input logic              cv,
    input logic [TAG_W-1:0]  ct,
    input logic [DATA_W-1:0] cd
  );
    if (name == '0) return {TagFree, {DATA_W{1'b0}}};
    if (cv && (tag != TagFree) && (ct == tag)) return {TagFree, cd};
    return {tag, data};
  endfunction

  assign src1 = resolve_src(head.rs1, rf_tag1, rf_data1, cdb_valid, cdb_tag, cdb_data);
  assign src2 = resolve_src(head.rs2, rf_tag2, rf_data2, cdb_valid, cdb_tag, cdb_data);

  // Dispatch decision: which unit, whether a destination tag is needed and available.
  always_comb begin
    needs_alu_tag = cls_alu_rename(cls) && rd_nz;
    needs_ls_tag  = ((cls == ClsLd) && rd_nz) || (cls == ClsSt);
    renames       = needs_alu_tag || ((cls == ClsLd) && rd_nz);
    tag_ok        = (!needs_alu_tag || alu_free_valid) && (!needs_ls_tag || ls_free_valid);
    case (tgt)
      TgtAlu:  tgt_ready = alu_ready;
      TgtBr:   tgt_ready = br_ready;
      TgtLs:   tgt_ready = ls_ready;
      default: tgt_ready = 1'b1;  // NONE heads drop without a consumer
    endcase
    go        = head_valid && tag_ok && !flush;
    alu_valid = go && (tgt == TgtAlu);
    br_valid  = go && (tgt == TgtBr);
    ls_valid  = go && (tgt == TgtLs);
    fire      = go && tgt_ready;
  end

  // Payload and rename outputs; everything reads as zero / free when nothing is offered.
  always_comb begin
    d_op     = '0;
    d_opnd1  = '0;
    d_opnd2  = '0;
    d_tag1   = TagFree;
    d_tag2   = TagFree;
    d_tagw   = TagFree;
    d_namew  = '0;
    d_imm    = '0;
    d_addr   = '0;
    if (alu_valid || br_valid || ls_valid) begin
      d_op   = head.op;
      d_imm  = head.imm;
      d_addr = head.addr;
      case (cls)
        ClsLui:         d_opnd1 = '0;
        ClsAuipc, ClsJal: d_opnd1 = head.addr;
        default:        {d_tag1, d_opnd1} = src1;
      endcase
      case (cls)
        ClsRr, ClsB, ClsSt: {d_tag2, d_opnd2} = src2;
        default:            d_opnd2 = head.imm;
      endcase
      if (needs_alu_tag)     d_tagw = {PREFIX_ALU, alu_free_tag};
      else if (needs_ls_tag) d_tagw = {PREFIX_LS, ls_free_tag};
      if (renames) d_namew = head.rd;
    end
    ren_en   = fire && renames;
    ren_name = ren_en ? head.rd : '0;
    ren_tag  = ren_en ? d_tagw : TagFree;
  end

  // Saturating count of cycles a valid head was held back.
  always_comb begin
    stall_d = stall_q;
    if (head_valid && !fire && !flush && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  // Stall counter state; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue: each step drives inputs, then checks outputs mid-cycle.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ROOT_W = 4;
  localparam int unsigned NAME_W = 5;
  localparam int unsigned TAG_W  = ROOT_W + 1;

  logic              clk, rst_n, flush;
  logic              in_valid, in_ready;
  logic [CLS_W-1:0]  in_cls;
  logic [OP_W-1:0]   in_op;
  logic [NAME_W-1:0] in_rs1, in_rs2, in_rd;
  logic [DATA_W-1:0] in_addr, in_imm;
  logic [NAME_W-1:0] rf_name1, rf_name2;
  logic [TAG_W-1:0]  rf_tag1, rf_tag2;
  logic [DATA_W-1:0] rf_data1, rf_data2;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              alu_free_valid, ls_free_valid;
  logic [ROOT_W-1:0] alu_free_tag, ls_free_tag;
  logic              ren_en;
  logic [NAME_W-1:0] ren_name;
  logic [TAG_W-1:0]  ren_tag;
  logic              alu_valid, br_valid, ls_valid, alu_ready, br_ready, ls_ready;
  logic [OP_W-1:0]   d_op;
  logic [DATA_W-1:0] d_opnd1, d_opnd2, d_imm, d_addr;
  logic [TAG_W-1:0]  d_tag1, d_tag2, d_tagw;
  logic [NAME_W-1:0] d_namew;
  logic [31:0]       stall_cnt;

  int checks = 0;
  int failures = 0;

  dispatch_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ROOT_W (ROOT_W),
    .NAME_W (NAME_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_cls         (in_cls),
    .in_op          (in_op),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_rd          (in_rd),
    .in_addr        (in_addr),
    .in_imm         (in_imm),
    .rf_name1       (rf_name1),
    .rf_name2       (rf_name2),
    .rf_tag1        (rf_tag1),
    .rf_tag2        (rf_tag2),
    .rf_data1       (rf_data1),
    .rf_data2       (rf_data2),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .alu_free_valid (alu_free_valid),
    .alu_free_tag   (alu_free_tag),
    .ls_free_valid  (ls_free_valid),
    .ls_free_tag    (ls_free_tag),
    .ren_en         (ren_en),
    .ren_name       (ren_name),
    .ren_tag        (ren_tag),
    .alu_valid      (alu_valid),
    .br_valid       (br_valid),
    .ls_valid       (ls_valid),
    .alu_ready      (alu_ready),
    .br_ready       (br_ready),
    .ls_ready       (ls_ready),
    .d_op           (d_op),
    .d_opnd1        (d_opnd1),
    .d_opnd2        (d_opnd2),
    .d_tag1         (d_tag1),
    .d_tag2         (d_tag2),
    .d_tagw         (d_tagw),
    .d_namew        (d_namew),
    .d_imm          (d_imm),
    .d_addr         (d_addr),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic enq(input dq_cls_e c, input logic [OP_W-1:0] op, input logic [NAME_W-1:0] r1,
                     input logic [NAME_W-1:0] r2, input logic [NAME_W-1:0] rd,
                     input logic [DATA_W-1:0] addr, input logic [DATA_W-1:0] imm);
    in_valid = 1'b1;
    in_cls   = c;
    in_op    = op;
    in_rs1   = r1;
    in_rs2   = r2;
    in_rd    = rd;
    in_addr  = addr;
    in_imm   = imm;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_cls = '0; in_op = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_addr = '0; in_imm = '0;
    rf_tag1 = '0; rf_tag2 = '0; rf_data1 = '0; rf_data2 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    alu_free_valid = 1'b0; alu_free_tag = '0; ls_free_valid = 1'b0; ls_free_tag = '0;
    alu_ready = 1'b0; br_ready = 1'b0; ls_ready = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_valid", alu_valid, 0);
    check("rst_br_valid", br_valid, 0);
    check("rst_ls_valid", ls_valid, 0);
    check("rst_ren_en", ren_en, 0);
    check("rst_stall", stall_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // RR x3 = x1 + x2 with both sources ready
    alu_free_valid = 1'b1; alu_free_tag = 4'd5; ls_free_valid = 1'b1; ls_free_tag = 4'd3;
    alu_ready = 1'b1; br_ready = 1'b1; ls_ready = 1'b1;
    rf_data1 = 32'd10; rf_data2 = 32'd20;
    enq(ClsRr, 6'h33, 5'd1, 5'd2, 5'd3, 32'h100, 32'h0);
    settle();
    check("rr_no_bypass", alu_valid, 0);
    tick();
    in_valid = 1'b0;
    settle();
    check("rr_alu_valid", alu_valid, 1);
    check("rr_tagw", d_tagw, 5'h05);
    check("rr_ren_en", ren_en, 1);
    check("rr_ren_name", ren_name, 3);
    check("rr_ren_tag", ren_tag, 5'h05);
    check("rr_opnd1", d_opnd1, 10);
    check("rr_opnd2", d_opnd2, 20);
    check("rr_rf_name1", rf_name1, 1);
    check("rr_rf_name2", rf_name2, 2);
    check("rr_op", d_op, 6'h33);
    check("rr_addr", d_addr, 32'h100);
    check("rr_namew", d_namew, 3);
    tick();
    settle();
    check("rr_drained", alu_valid, 0);
    check("rr_idle_tagw", d_tagw, 0);
    check("rr_idle_ren", ren_en, 0);
    check("rr_stall", stall_cnt, 0);

    // RI with a pending source, later satisfied by the broadcast
    alu_free_tag = 4'd9; rf_tag1 = 5'h12; rf_data1 = 32'h1111;
    enq(ClsRi, 6'h13, 5'd4, 5'd0, 5'd6, 32'h104, 32'd7);
    tick();
    in_valid = 1'b0; alu_ready = 1'b0;
    settle();
    check("ri_valid_unready", alu_valid, 1);
    check("ri_tag1_pending", d_tag1, 5'h12);
    check("ri_opnd1_rf", d_opnd1, 32'h1111);
    check("ri_opnd2_imm", d_opnd2, 7);
    check("ri_tag2_free", d_tag2, 0);
    check("ri_no_ren", ren_en, 0);
    tick();
    settle();
    check("ri_stall1", stall_cnt, 1);
    cdb_valid = 1'b1; cdb_tag = 5'h12; cdb_data = 32'hDEAD; alu_ready = 1'b1;
    settle();
    check("fwd_opnd1", d_opnd1, 32'hDEAD);
    check("fwd_tag1", d_tag1, 0);
    check("fwd_ren_en", ren_en, 1);
    check("fwd_ren_tag", ren_tag, 5'h09);
    check("fwd_ren_name", ren_name, 6);
    tick();
    cdb_valid = 1'b0;
    settle();
    check("fwd_drained", alu_valid, 0);
    check("fwd_stall_hold", stall_cnt, 1);

    // RI with rd = x0 needs no free tag
    alu_free_valid = 1'b0; rf_tag1 = '0; rf_data1 = 32'd10;
    enq(ClsRi, 6'h13, 5'd1, 5'd0, 5'd0, 32'h108, 32'd3);
    tick();
    in_valid = 1'b0;
    settle();
    check("rd0_valid", alu_valid, 1);
    check("rd0_tagw", d_tagw, 0);
    check("rd0_ren", ren_en, 0);
    check("rd0_namew", d_namew, 0);
    tick();
    settle();
    check("rd0_drained", alu_valid, 0);
    alu_free_valid = 1'b1;

    // Branch reading x0 as rs1 while the regfile presents junk
    rf_tag1 = 5'h07; rf_data1 = 32'h55; rf_tag2 = '0; rf_data2 = 32'd20;
    enq(ClsB, 6'h63, 5'd0, 5'd2, 5'd0, 32'h10C, 32'h40);
    tick();
    in_valid = 1'b0;
    settle();
    check("b_br_valid", br_valid, 1);
    check("b_alu_valid", alu_valid, 0);
    check("b_x0_opnd1", d_opnd1, 0);
    check("b_x0_tag1", d_tag1, 0);
    check("b_opnd2", d_opnd2, 20);
    check("b_tagw", d_tagw, 0);
    check("b_ren", ren_en, 0);
    check("b_imm", d_imm, 32'h40);
    tick();

    // Store takes an LS tag but never renames
    rf_tag1 = '0; rf_data1 = 32'h2000; rf_data2 = 32'hBEEF;
    enq(ClsSt, 6'h23, 5'd1, 5'd2, 5'd0, 32'h110, 32'd8);
    tick();
    in_valid = 1'b0;
    settle();
    check("st_ls_valid", ls_valid, 1);
    check("st_tagw", d_tagw, 5'h13);
    check("st_namew", d_namew, 0);
    check("st_ren", ren_en, 0);
    check("st_opnd2", d_opnd2, 32'hBEEF);
    tick();
    settle();
    check("st_stall_hold", stall_cnt, 1);

    // Four loads against a busy LS unit: fill (with pointer wrap), stall, drain in order
    ls_ready = 1'b0; rf_data1 = 32'h1000;
    for (int i = 1; i <= 4; i++) begin
      enq(ClsLd, 6'h03, 5'd1, 5'd0, NAME_W'(i), 32'h120 + 32'(4 * i), 32'(4 * i));
      settle();
      check("ld_fill_ready", in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
    settle();
    check("ld_full", in_ready, 0);
    check("ld_head_valid", ls_valid, 1);
    check("ld_stall_fill", stall_cnt, 4);
    tick();
    settle();
    check("ld_stall_more", stall_cnt, 5);
    ls_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      check("ld_drain_valid", ls_valid, 1);
      check("ld_drain_name", d_namew, 64'(i));
      check("ld_drain_imm", d_imm, 64'(4 * i));
      check("ld_drain_tag", ren_tag, 5'h13);
      tick();
    end
    settle();
    check("ld_empty", ls_valid, 0);
    check("ld_ready", in_ready, 1);
    check("ld_stall_final", stall_cnt, 5);

    // Flush with three ops queued; the concurrent enqueue must be discarded
    alu_ready = 1'b0; rf_data1 = '0; rf_data2 = '0;
    for (int i = 1; i <= 3; i++) begin
      enq(ClsRr, 6'h33, 5'd1, 5'd2, NAME_W'(i), 32'h200, 32'h0);
      tick();
    end
    settle();
    check("fl_pre_valid", alu_valid, 1);
    flush = 1'b1;
    settle();
    check("fl_no_valid", alu_valid, 0);
    check("fl_no_ren", ren_en, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    settle();
    check("fl_empty", alu_valid, 0);
    check("fl_ready", in_ready, 1);
    check("fl_stall_kept", stall_cnt, 7);

    // Reset while an op is being dispatched
    alu_ready = 1'b1;
    enq(ClsRr, 6'h33, 5'd1, 5'd2, 5'd3, 32'h300, 32'h0);
    tick();
    in_valid = 1'b0;
    settle();
    check("mr_pre_valid", alu_valid, 1);
    check("mr_pre_ren", ren_en, 1);
    rst_n = 1'b0;
    #1;
    check("mr_valid", alu_valid, 0);
    check("mr_ren", ren_en, 0);
    check("mr_stall", stall_cnt, 0);
    check("mr_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch_queue.md
DISPATCH_QUEUE -- requirements
Module: dispatch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, minimum 2.
REQ-002 Parameter DATA_W, default 32, operand/immediate/address width.
REQ-003 Parameter ROOT_W, default 4, free-tag root width; tag width TAG_W = ROOT_W+1 (MSB = prefix: 1 = LS, 0 = ALU).
REQ-004 Parameter NAME_W, default 5, architectural register name width.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low. Ports: clk in 1, rising-edge clock; rst_n in 1, async active-low reset.
REQ-006 flush  in  1  mispredict flush.
REQ-007 in_valid/in_ready  in/out  1/1  decoder handshake.
REQ-008 in_cls  in  4  op class (NONE, LUI, AUIPC, JAL, JALR, B, LD, ST, RI, RR); in_op  in  6  opcode.
REQ-009 in_rs1, in_rs2, in_rd  in  NAME_W each  source/destination names; in_addr  in  DATA_W  PC; in_imm  in  DATA_W  pre-selected immediate.
REQ-010 rf_name1, rf_name2  out  NAME_W  regfile read names, driven from queue head; rf_tag1/rf_tag2  in  TAG_W; rf_data1/rf_data2  in  DATA_W.
REQ-011 cdb_valid  in  1; cdb_tag  in  TAG_W; cdb_data  in  DATA_W  result broadcast.
REQ-012 alu_free_valid  in  1; alu_free_tag  in  ROOT_W; ls_free_valid  in  1; ls_free_tag  in  ROOT_W.
REQ-013 ren_en  out  1; ren_name  out  NAME_W; ren_tag  out  TAG_W  rename write to regfile.
REQ-014 alu_valid, br_valid, ls_valid  out  1 each; alu_ready, br_ready, ls_ready  in  1 each.
REQ-015 Shared payload outputs: d_op 6, d_opnd1/d_opnd2 DATA_W, d_tag1/d_tag2 TAG_W, d_tagw TAG_W, d_namew NAME_W, d_imm DATA_W, d_addr DATA_W.
REQ-016 stall_cnt  out  32  saturating count of cycles head valid but not dispatched.

Function
REQ-017 Enqueue when in_valid && in_ready && !flush; in_ready = (count < DEPTH); no same-cycle bypass, earliest dispatch one cycle after enqueue.
REQ-018 Head target: ALU for LUI/AUIPC/JAL/JALR/RI/RR, BR for B, LS for LD/ST; NONE heads are dequeued silently with no valid and no rename.
REQ-019 Tag needed: ALU-rename class with rd != 0 needs alu_free_valid; LD with rd != 0 and ST need ls_free_valid; B and rd == 0 need none.
REQ-020 Fire = head valid && target ready && tag available && !flush; target valid asserted whenever head valid, tag available and !flush, independent of ready.
REQ-021 Operand mapping: LUI opnd1=0; AUIPC/JAL opnd1=d_addr; others opnd1=rs1; opnd2=rs2 for RR/B/ST, else in_imm; unused operands = 0 with tag TAG_FREE.
REQ-022 Source forwarding: if cdb_valid && cdb_tag == rf_tagN, opnd = cdb_data and tag = TAG_FREE; register x0 always data 0, TAG_FREE.
REQ-023 d_tagw = {prefix, free root}; TAG_FREE for B and rd == 0; ST gets an LS tag but d_namew = 0 and no rename.
REQ-024 ren_en = fire && rd != 0 && class not B/ST/NONE; ren_name = rd, ren_tag = d_tagw.
REQ-025 Inactive payload outputs are 0 / TAG_FREE; only one of alu/br/ls_valid high per cycle.
REQ-026 Wrap-around: read/write pointers mod DEPTH; full and empty distinguished by count register.
REQ-027 flush: count, pointers cleared next edge; no valid, no ren_en in flush cycle; stall_cnt not cleared.
REQ-028 stall_cnt increments when head valid and not fired and !flush; saturates at 0xFFFFFFFF.

Reset
REQ-029 rst_n low: count, pointers, stall_cnt = 0; in_ready = 1; all valids and ren_en = 0 asynchronously; queue contents need not be cleared.

Structure
REQ-030 Shared package holds class encodings, TAG_FREE, prefix constants, opcode width.
REQ-031 One sub-module natural: dq_fifo (parametrised storage, pointers, count, flush).

Verification
REQ-032 RR x3=x1+x2, regs ready, alu_free tag 5 -> one cycle after enqueue alu_valid, d_tagw=0x05, ren_en with name 3.
REQ-033 Four LDs with ls_ready=0 -> in_ready=0 after 4th; stall_cnt increments per cycle; ls_ready=1 drains in 4 cycles in order.
REQ-034 Head rf_tag1=0x12 with cdb_valid, tag 0x12, data 0xDEAD -> d_opnd1=0xDEAD, d_tag1=TAG_FREE.
REQ-035 RI with rd=0 and alu_free_valid=0 -> dispatch, d_tagw=TAG_FREE, ren_en=0.
REQ-036 flush with 3 entries queued -> no valid that cycle, count=0 next cycle, in_ready=1.
REQ-037 rst_n low mid-dispatch -> all valids drop immediately, stall_cnt=0.
